// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Forwarding, load-use, branch-flush and memory-wait controller for
//            the five-stage pipeline. Optional saturating stall/flush counters
//            are built when HAZARD_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        ResultSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReqM,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_cycles
);

    localparam int c_WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(MEM_LAT - 1);
    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_WB  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;
    localparam logic [1:0] c_RES_LOAD = 2'b01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    logic w_lwStall;
    logic w_memStall;

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdM,
        input logic [REG_AW-1:0] rdW,
        input logic              wrM,
        input logic              wrW
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (wrM && (rdM == rs) && (rs != '0)) begin
            sel = c_FWD_MEM;
        end else if (wrW && (rdW == rs) && (rs != '0)) begin
            sel = c_FWD_WB;
        end
        return sel;
    endfunction

    assign w_lwStall = (ResultSrcE == c_RES_LOAD) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));

    generate
        if (MEM_LAT > 1) begin : g_memWait
            state_t              r_state;
            state_t              w_stateNext;
            logic [c_WCNT_W-1:0] r_wcnt;
            logic [c_WCNT_W-1:0] w_wcntNext;

            // The op is released in the cycle its count reaches the last slot.
            assign w_memStall = MemReqM && !((r_state == WAIT) && (r_wcnt == c_WCNT_LAST));

            always_comb begin
                w_stateNext = r_state;
                w_wcntNext  = r_wcnt;
                case (r_state)
                    IDLE: begin
                        if (MemReqM) begin
                            w_stateNext = WAIT;
                            w_wcntNext  = c_WCNT_W'(1);
                        end
                    end
                    WAIT: begin
                        if (!MemReqM || (r_wcnt == c_WCNT_LAST)) begin
                            w_stateNext = IDLE;
                            w_wcntNext  = '0;
                        end else begin
                            w_wcntNext  = r_wcnt + c_WCNT_W'(1);
                        end
                    end
                    default: begin
                        w_stateNext = IDLE;
                        w_wcntNext  = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= IDLE;
                    r_wcnt  <= '0;
                end else begin
                    r_state <= w_stateNext;
                    r_wcnt  <= w_wcntNext;
                end
            end
        end else begin : g_noMemWait
            logic w_unusedNoWait;
            assign w_memStall     = 1'b0;
            assign w_unusedNoWait = ^{clk, MemReqM};
        end
    endgenerate

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = fwdSel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
        ForwardBE = fwdSel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
        if (rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            ForwardAE = c_FWD_RF;
            ForwardBE = c_FWD_RF;
        end else if (w_memStall) begin
            // E is frozen, so load-use and branch are re-evaluated after release.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = w_lwStall;
            StallD = w_lwStall;
            FlushD = PCSrcE;
            FlushE = w_lwStall | PCSrcE;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushCycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCycles <= '0;
        end else begin
            if ((w_lwStall || w_memStall) && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if (PCSrcE && !w_memStall && (r_flushCycles != '1)) begin
                r_flushCycles <= r_flushCycles + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_cycles = r_flushCycles;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed bench for hazard_ctrl (MEM_LAT=3, CNT_W=4) with a
//            reference model and a MEM_LAT=1 companion instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int AW   = 5;
    localparam int LAT  = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam int EXP_STALL = 15;
    localparam int EXP_FLUSH = 3;
`else
    localparam int EXP_STALL = 0;
    localparam int EXP_FLUSH = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, MemReqM, PCSrcE;

    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cycles, flush_cycles;

    logic          StallF1, StallD1, StallE1, StallM1, FlushD1, FlushE1, FlushW1;
    logic [1:0]    ForwardAE1, ForwardBE1;
    logic [CW-1:0] stall_cycles1, flush_cycles1;

    hazard_ctrl #(.REG_AW(AW), .MEM_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    hazard_ctrl #(.REG_AW(AW), .MEM_LAT(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .PCSrcE(PCSrcE),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .StallM(StallM1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushW(FlushW1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
        .stall_cycles(stall_cycles1), .flush_cycles(flush_cycles1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: how many cycles the op currently in M has already waited.
    int mAge    = 0;
    int sc      = 0;
    int fc      = 0;
    bit modelOn = 1'b0;

    function automatic bit modelLw();
        return (ResultSrcE == 2'b01) && (RdE != 0) && ((Rs1D == RdE) || (Rs2D == RdE));
    endfunction

    function automatic bit modelMem(input int lat);
        return MemReqM && (mAge < lat - 1);
    endfunction

    function automatic logic [1:0] modelFwd(input logic [AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        modelOn <= 1'b1;
        if (rst) begin
            mAge <= 0;
            sc   <= 0;
            fc   <= 0;
        end else begin
            mAge <= modelMem(LAT) ? mAge + 1 : 0;
            if ((modelLw() || modelMem(LAT)) && sc < CMAX) sc <= sc + 1;
            if (PCSrcE && !modelMem(LAT) && fc < CMAX) fc <= fc + 1;
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            logic [3:0] expS, expS1;
            logic [2:0] expF, expF1;
            bit lw, ms;
            lw = modelLw();
            ms = modelMem(LAT);
            if (rst) begin
                expS = 4'b0000; expF = 3'b111;
                expS1 = 4'b0000; expF1 = 3'b111;
            end else begin
                expS1 = {lw, lw, 2'b00};
                expF1 = {PCSrcE, lw | PCSrcE, 1'b0};
                if (ms) begin
                    expS = 4'b1111; expF = 3'b001;
                end else begin
                    expS = expS1; expF = expF1;
                end
            end
            chk("stalls",      {StallF, StallD, StallE, StallM}, expS);
            chk("flushes",     {FlushD, FlushE, FlushW}, expF);
            chk("fwdA",        ForwardAE, rst ? 2'b00 : modelFwd(Rs1E));
            chk("fwdB",        ForwardBE, rst ? 2'b00 : modelFwd(Rs2E));
            chk("stalls_lat1", {StallF1, StallD1, StallE1, StallM1}, expS1);
            chk("flushes_lat1",{FlushD1, FlushE1, FlushW1}, expF1);
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt", stall_cycles, sc);
            chk("flush_cnt", flush_cycles, fc);
`else
            chk("stall_cnt", stall_cycles, 0);
            chk("flush_cnt", flush_cycles, 0);
`endif
        end
    end

    task automatic clearIn();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; PCSrcE = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        clearIn();
        // Reset cycle with a forwardable match and a memory request present.
        rst = 1; Rs1E = 5; RdM = 5; RegWriteM = 1; MemReqM = 1;
        mid();
        chk("rst_stalls",  {StallF, StallD, StallE, StallM}, 4'b0000);
        chk("rst_flushes", {FlushD, FlushE, FlushW}, 3'b111);
        chk("rst_fwdA",    ForwardAE, 2'b00);
        nextCycle(); nextCycle();
        rst = 0; clearIn();

        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        mid(); chk("fwd_m_beats_w", ForwardAE, 2'b10);
        nextCycle(); RegWriteM = 0;
        mid(); chk("fwd_w", ForwardAE, 2'b01);
        nextCycle(); Rs1E = 0;
        mid(); chk("fwd_x0", ForwardAE, 2'b00);
        nextCycle(); Rs2E = 3; RdW = 3; RdM = 3;
        mid(); chk("fwdB_w", ForwardBE, 2'b01);

        nextCycle(); clearIn(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        mid();
        chk("lu_stall", {StallF, StallD, FlushE}, 3'b111);
        chk("lu_noEM",  {StallE, StallM, FlushD}, 3'b000);
        nextCycle(); ResultSrcE = 2'b00;
        mid(); chk("lu_one_bubble", {StallF, StallD, FlushE}, 3'b000);
        nextCycle(); ResultSrcE = 2'b01; RdE = 0; Rs2D = 0; Rs1D = 0;
        mid(); chk("lu_x0", {StallF, StallD, FlushE}, 3'b000);

        nextCycle(); clearIn(); PCSrcE = 1;
        mid(); chk("br_flush", {StallF, StallD, FlushD, FlushE}, 4'b0011);
        nextCycle(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        mid(); chk("br_lu", {StallF, StallD, FlushD, FlushE}, 4'b1111);

        // Two back-to-back memory ops, each holding the pipe for two cycles.
        nextCycle(); clearIn(); MemReqM = 1;
        mid();
        chk("mem_w1", {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
        chk("lat1_nostall", StallM1, 1'b0);
        nextCycle(); PCSrcE = 1;
        mid(); chk("mem_w2_br_masked", {StallM, FlushD, FlushE, FlushW}, 4'b1001);
        nextCycle(); PCSrcE = 0;
        mid(); chk("mem_release", {StallF, StallM, FlushW}, 3'b000);
        nextCycle();
        mid(); chk("mem2_w1", {StallF, StallM, FlushW}, 3'b111);
        nextCycle();
        mid(); chk("mem2_w2", {StallF, StallM, FlushW}, 3'b111);
        nextCycle();
        mid(); chk("mem2_release", {StallF, StallM, FlushW}, 3'b000);

        // Reset in the second wait cycle aborts the wait.
        nextCycle(); clearIn(); nextCycle(); MemReqM = 1;
        mid(); chk("rw_w1", StallM, 1'b1);
        nextCycle(); rst = 1;
        mid(); chk("rw_rst", {StallM, FlushD, FlushE, FlushW}, 4'b0111);
        nextCycle(); rst = 0;
        mid(); chk("rw_restart", StallM, 1'b1);
        nextCycle();
        mid(); chk("rw_w2", StallM, 1'b1);
        nextCycle();
        mid(); chk("rw_release", StallM, 1'b0);

        // Counters: 3 honoured branches, then 20 load-use cycles.
        nextCycle(); clearIn(); rst = 1;
        nextCycle(); rst = 0; PCSrcE = 1;
        nextCycle(); nextCycle(); nextCycle();
        PCSrcE = 0;
        chk("flush_cnt_3", flush_cycles, EXP_FLUSH);
        ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
        for (int i = 0; i < 20; i++) nextCycle();
        clearIn();
        chk("stall_cnt_sat", stall_cycles, EXP_STALL);
        chk("flush_cnt_hold", flush_cycles, EXP_FLUSH);

        nextCycle(); nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
